// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and grant-selection helpers for the memory arbiter.
// MEM_ARB_FIXED_PRIO_EN (defined in mem_arb.sv builds) selects fp_pick instead of rr_pick.
package mem_arb_pkg;

  // Widest engine count the helpers are sized for.
  localparam int MAX_MST   = 8;
  localparam int N_MST_DEF = 4;
  // Tag width for the default engine count.
  localparam int TAG_W     = $clog2(N_MST_DEF);

  // Round-robin pick: first set bit of req scanning from ptr+1 (mod n), one-hot result.
  function automatic logic [MAX_MST-1:0] rr_pick(input logic [MAX_MST-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input int unsigned        n);
    logic [MAX_MST-1:0] gnt;
    logic               found;
    int unsigned        idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_MST; k++) begin
      if (k <= n) begin
        idx = (32'(ptr) + k) % n;
        if (!found && req[idx[2:0]]) begin
          gnt[idx[2:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

  // Fixed priority pick: lowest set bit wins, one-hot result.
  function automatic logic [MAX_MST-1:0] fp_pick(input logic [MAX_MST-1:0] req);
    logic [MAX_MST-1:0] gnt;
    logic               found;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_MST; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: engine-side and memory-side bus of the memory arbiter.
// slave = arbiter view, master = the engines/memory driving it.
interface mem_arb_if #(
  parameter int N_MST  = 4,
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32
);
  logic [N_MST-1:0]        m_req;
  logic [N_MST-1:0]        m_write;
  logic [N_MST*MEM_AW-1:0] m_addr;
  logic [N_MST*MEM_DW-1:0] m_wdata;
  logic [N_MST-1:0]        m_ena;
  logic [N_MST-1:0]        m_rdata_vld;
  logic [N_MST*MEM_DW-1:0] m_rdata;
  logic                    mem_req;
  logic                    mem_write;
  logic [MEM_AW-1:0]       mem_addr;
  logic [MEM_DW-1:0]       mem_wdata;
  logic                    mem_ready;
  logic                    mem_rdata_vld;
  logic [MEM_DW-1:0]       mem_rdata;
  logic                    err;

  modport slave (
    input  m_req, m_write, m_addr, m_wdata, mem_ready, mem_rdata_vld, mem_rdata,
    output m_ena, m_rdata_vld, m_rdata, mem_req, mem_write, mem_addr, mem_wdata, err
  );

  modport master (
    output m_req, m_write, m_addr, m_wdata, mem_ready, mem_rdata_vld, mem_rdata,
    input  m_ena, m_rdata_vld, m_rdata, mem_req, mem_write, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_arb_fifo.sv
// mem_arb_fifo: small synchronous FIFO with a combinational head output.
// Pushes when full and pops when empty are ignored.
module mem_arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CNTW-1:0]  cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt == CNTW'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      cnt <= cnt + CNTW'(1);
      else if (do_pop && !do_push) cnt <= cnt - CNTW'(1);
    end
  end

  // Storage array; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one memory port between N_MST engines.
// Reads are tagged with the issuing engine and routed back through per-engine
// response FIFOs; a per-engine credit counter bounds outstanding reads.
// Build option: MEM_ARB_FIXED_PRIO_EN selects lowest-index-wins arbitration.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int N_MST     = 4,
  parameter int MEM_AW    = 16,
  parameter int MEM_DW    = 32,
  parameter int RSP_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  bus
);
  // Tag width for this instance's engine count.
  localparam int TW     = $clog2(N_MST);
  localparam int CW     = $clog2(RSP_DEPTH + 1);
  localparam int TDEPTH = N_MST * RSP_DEPTH;

  logic [N_MST-1:0]   elig;
  logic [N_MST-1:0]   grant;
  logic [N_MST-1:0]   rd_gnt;
  logic [N_MST-1:0]   ena;
  logic [N_MST-1:0]   rvld;
  logic [MAX_MST-1:0] pick;
  logic [TW-1:0]      gidx;
  logic               gnt_any;
  logic [CW-1:0]      out_cnt [N_MST];
  logic               err_q;

  logic               tag_push;
  logic               tag_pop;
  logic               tag_full;
  logic               tag_empty;
  logic [TW-1:0]      tag_head;

  logic               rsp_push  [N_MST];
  logic               rsp_full  [N_MST];
  logic               rsp_empty [N_MST];
  logic [MEM_DW-1:0]  rsp_head  [N_MST];
  logic               unused_full;

  // Eligibility: writes always, reads only while credit remains.
  always_comb begin
    for (int i = 0; i < N_MST; i++) begin
      elig[i] = bus.m_req[i] & (bus.m_write[i] | (out_cnt[i] < CW'(RSP_DEPTH)));
    end
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Grant selection, qualified by memory readiness and held off during reset.
  always_comb begin
    pick  = fp_pick(MAX_MST'(elig));
    grant = (bus.mem_ready && !rst) ? pick[N_MST-1:0] : '0;
  end
`else
  logic [TW-1:0] rr_ptr;

  // Grant selection, qualified by memory readiness and held off during reset.
  always_comb begin
    pick  = rr_pick(MAX_MST'(elig), 3'(rr_ptr), unsigned'(N_MST));
    grant = (bus.mem_ready && !rst) ? pick[N_MST-1:0] : '0;
  end

  // Round-robin pointer follows the last granted engine; reset favours engine 0.
  always_ff @(posedge clk) begin
    if (rst)          rr_ptr <= TW'(N_MST - 1);
    else if (gnt_any) rr_ptr <= gidx;
  end
`endif

  // Encode the one-hot grant and steer the winner onto the memory port.
  always_comb begin
    gidx          = '0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (grant[i]) begin
        gidx          = TW'(i);
        bus.mem_write = bus.m_write[i];
        bus.mem_addr  = bus.m_addr[i*MEM_AW +: MEM_AW];
        bus.mem_wdata = bus.m_wdata[i*MEM_DW +: MEM_DW];
      end
    end
  end

  assign gnt_any     = |grant;
  assign bus.mem_req = gnt_any;
  assign rd_gnt      = grant & ~bus.m_write;
  assign tag_push    = |rd_gnt;
  assign tag_pop     = bus.mem_rdata_vld & ~tag_empty;

  // Engine stall/run and response delivery to unfrozen engines.
  always_comb begin
    ena = rst ? '0 : (~bus.m_req | grant);
    for (int i = 0; i < N_MST; i++) begin
      rvld[i]                          = ~rsp_empty[i] & ena[i];
      bus.m_rdata[i*MEM_DW +: MEM_DW]  = rsp_head[i];
    end
    bus.m_ena       = ena;
    bus.m_rdata_vld = rvld;
  end

  // Issue-order record of which engine owns each outstanding read.
  mem_arb_fifo #(
    .WIDTH (TW),
    .DEPTH (TDEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .din   (gidx),
    .pop   (tag_pop),
    .full  (tag_full),
    .empty (tag_empty),
    .head  (tag_head)
  );

  for (genvar g = 0; g < N_MST; g++) begin : g_rsp
    assign rsp_push[g] = tag_pop & (tag_head == TW'(g));

    mem_arb_fifo #(
      .WIDTH (MEM_DW),
      .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rsp_push[g]),
      .din   (bus.mem_rdata),
      .pop   (rvld[g]),
      .full  (rsp_full[g]),
      .empty (rsp_empty[g]),
      .head  (rsp_head[g])
    );
  end

  // Full flags are never needed: credits keep every FIFO from overflowing.
  always_comb begin
    unused_full = tag_full;
    for (int i = 0; i < N_MST; i++) unused_full = unused_full | rsp_full[i];
  end

  // Outstanding-read credits: up on read grant, down on delivery.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_MST; i++) out_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_MST; i++) begin
        if (rd_gnt[i] && !rvld[i])      out_cnt[i] <= out_cnt[i] + CW'(1);
        else if (!rd_gnt[i] && rvld[i]) out_cnt[i] <= out_cnt[i] - CW'(1);
      end
    end
  end

  // Sticky flag for read data arriving with no read outstanding.
  always_ff @(posedge clk) begin
    if (rst)                                  err_q <= 1'b0;
    else if (bus.mem_rdata_vld && tag_empty)  err_q <= 1'b1;
  end

  assign bus.err = err_q;

endmodule
